// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - stall bit indices into the {data, exe, id, inst} stall vector
//   - cumulative stall patterns (a stall at stage k also freezes every earlier stage)
//   - controller FSM state encoding
//   - default exception redirect vector
package pipeline_ctrl_pkg;

  localparam int unsigned STALL_INST = 0;
  localparam int unsigned STALL_ID   = 1;
  localparam int unsigned STALL_EXE  = 2;
  localparam int unsigned STALL_DATA = 3;

  // Pattern that freezes stage idx and everything upstream of it.
  function automatic logic [3:0] stall_mask(input int unsigned idx);
    stall_mask = 4'((5'd1 << (idx + 1)) - 5'd1);
  endfunction

  localparam logic [3:0] STALL_NONE     = 4'b0000;
  localparam logic [3:0] STALL_PAT_INST = stall_mask(STALL_INST);
  localparam logic [3:0] STALL_PAT_ID   = stall_mask(STALL_ID);
  localparam logic [3:0] STALL_PAT_EXE  = stall_mask(STALL_EXE);
  localparam logic [3:0] STALL_PAT_DATA = stall_mask(STALL_DATA);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    EXC_DRAIN = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

endpackage

// File: rtl/sat_counter32.sv
// sat_counter32
// 32-bit up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock_i       system clock
//   reset_i       synchronous active-high reset, clears the count
//   load_i        load load_value_i (takes priority over inc_i)
//   load_value_i  value to load
//   inc_i         count one event this cycle
//   count_o       current count
module sat_counter32 (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] load_value_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_o <= 32'd0;
    end else if (load_i) begin
      count_o <= load_value_i;
    end else if (inc_i && (count_o != 32'hFFFFFFFF)) begin
      count_o <= count_o + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush controller for the 5-stage pipeline. Merges IF/ID/EX/MEM
// hazard and busy requests into one cumulative stall vector, sequences the
// multi-cycle divider and holds a pending exception until the data bus drains.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RUN       | normal flow; stalls follow the current requests
//   DIV_WAIT  | divider running; EX and upstream frozen until div_done_i
//   EXC_DRAIN | exception taken behind bus traffic; all frozen, target held
//
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   if_busy_i                 fetch not complete
//   id_load_use_i             load-use hazard in ID
//   ex_div_req_i              DIV/DIVU in EX (level)
//   div_done_i                divider result valid (pulse)
//   mem_busy_i                data-bus transaction outstanding
//   exc_req_i, exc_is_eret_i  exception/ERET commit from MEM
//   cp0_epc_i                 ERET return address
//   stall_o                   {data, exe, id, inst} stall vector
//   flush_o, new_pc_o         flush all stages and redirect fetch
//   div_start_o, div_cancel_o divider start/abort pulses
//   stall_cycles_o            saturating count of stalled, non-flush cycles
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        if_busy_i,
  input  logic        id_load_use_i,
  input  logic        ex_div_req_i,
  input  logic        div_done_i,
  input  logic        mem_busy_i,
  input  logic        exc_req_i,
  input  logic        exc_is_eret_i,
  input  logic [31:0] cp0_epc_i,
  output logic [3:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        div_start_o,
  output logic        div_cancel_o,
  output logic [31:0] stall_cycles_o
);

  ctrl_state_e state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] exc_target;
  logic [3:0]  req_stall;

  assign exc_target = exc_is_eret_i ? cp0_epc_i : EXC_VECTOR;

  // Cumulative encoding means OR-ing the patterns yields the strongest one.
  assign req_stall = (mem_busy_i    ? STALL_PAT_DATA : STALL_NONE)
                   | (id_load_use_i ? STALL_PAT_ID   : STALL_NONE)
                   | (if_busy_i     ? STALL_PAT_INST : STALL_NONE);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= RUN;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    stall_o      = STALL_NONE;
    flush_o      = 1'b0;
    new_pc_o     = 32'd0;
    div_start_o  = 1'b0;
    div_cancel_o = 1'b0;
    state_d      = state_q;
    target_d     = target_q;

    if (!reset_i) begin
      case (state_q)
        RUN, DIV_WAIT: begin
          if (exc_req_i) begin
            // The excepting instruction in MEM is older than the divide in EX.
            div_cancel_o = (state_q == DIV_WAIT);
            if (!mem_busy_i) begin
              flush_o  = 1'b1;
              new_pc_o = exc_target;
              state_d  = RUN;
            end else begin
              stall_o  = STALL_PAT_DATA;
              target_d = exc_target;
              state_d  = EXC_DRAIN;
            end
          end else if (state_q == RUN) begin
            stall_o = req_stall;
            if (ex_div_req_i) begin
              div_start_o = 1'b1;
              stall_o     = req_stall | STALL_PAT_EXE;
              state_d     = DIV_WAIT;
            end
          end else begin
            // Releasing EX in the done cycle lets it capture the quotient.
            if (div_done_i) begin
              stall_o = req_stall;
              state_d = RUN;
            end else begin
              stall_o = req_stall | STALL_PAT_EXE;
            end
          end
        end

        EXC_DRAIN: begin
          if (mem_busy_i) begin
            stall_o = STALL_PAT_DATA;
          end else begin
            flush_o  = 1'b1;
            new_pc_o = target_q;
            state_d  = RUN;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  sat_counter32 u_stall_cnt (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_i       (1'b0),
    .load_value_i (32'd0),
    .inc_i        ((stall_o != STALL_NONE) && !flush_o),
    .count_o      (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        if_busy_i, id_load_use_i, ex_div_req_i, div_done_i;
  logic        mem_busy_i, exc_req_i, exc_is_eret_i;
  logic [31:0] cp0_epc_i;
  logic [3:0]  stall_o;
  logic        flush_o, div_start_o, div_cancel_o;
  logic [31:0] new_pc_o, stall_cycles_o;

  logic        sc_load, sc_inc;
  logic [31:0] sc_value, sc_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock_i = ~clock_i;

  pipeline_ctrl dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .if_busy_i      (if_busy_i),
    .id_load_use_i  (id_load_use_i),
    .ex_div_req_i   (ex_div_req_i),
    .div_done_i     (div_done_i),
    .mem_busy_i     (mem_busy_i),
    .exc_req_i      (exc_req_i),
    .exc_is_eret_i  (exc_is_eret_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .div_start_o    (div_start_o),
    .div_cancel_o   (div_cancel_o),
    .stall_cycles_o (stall_cycles_o)
  );

  // Separate counter instance so saturation can be reached from a preload.
  sat_counter32 u_sat (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_i       (sc_load),
    .load_value_i (sc_value),
    .inc_i        (sc_inc),
    .count_o      (sc_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Apply inputs just after the edge, then move to mid-cycle for checking.
  task automatic drive(input logic ifb, input logic lu, input logic dr, input logic dd,
                       input logic mb, input logic er, input logic eret, input logic [31:0] epc);
    if_busy_i = ifb; id_load_use_i = lu; ex_div_req_i = dr; div_done_i = dd;
    mem_busy_i = mb; exc_req_i = er; exc_is_eret_i = eret; cp0_epc_i = epc;
    #4;
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] st, input logic fl,
                         input logic [31:0] pc, input logic ds, input logic dc);
    chk({tag, ".stall"},  32'(stall_o),      32'(st));
    chk({tag, ".flush"},  32'(flush_o),      32'(fl));
    chk({tag, ".new_pc"}, new_pc_o,          pc);
    chk({tag, ".start"},  32'(div_start_o),  32'(ds));
    chk({tag, ".cancel"}, 32'(div_cancel_o), 32'(dc));
  endtask

  initial begin
    reset_i = 1'b1; sc_load = 1'b0; sc_inc = 1'b0; sc_value = 32'd0;
    drive(1, 1, 1, 0, 0, 1, 0, 32'h0);
    step();
    // Outputs forced low during reset even with requests active.
    drive(1, 1, 1, 0, 0, 1, 0, 32'h0);
    chk_out("reset", 4'b0000, 0, 32'h0, 0, 0);
    step();
    reset_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("reset.cnt", stall_cycles_o, 32'd0);
    step();

    // Load-use bubble.
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk_out("lu.c0", 4'b0011, 0, 32'h0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("lu.c1.stall", 32'(stall_o), 32'h0);
    chk("lu.cnt", stall_cycles_o, 32'd1);
    step();

    // Divide: done in start cycle is ignored; real done in cycle 5.
    drive(0, 0, 1, 1, 0, 0, 0, 32'h0);
    chk_out("div.c0", 4'b0111, 0, 32'h0, 1, 0);
    step();
    for (int c = 1; c < 5; c++) begin
      drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
      chk_out($sformatf("div.c%0d", c), 4'b0111, 0, 32'h0, 0, 0);
      step();
    end
    drive(0, 0, 1, 1, 0, 0, 0, 32'h0);
    chk_out("div.c5", 4'b0000, 0, 32'h0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk_out("div.c6", 4'b0000, 0, 32'h0, 0, 0);
    chk("div.cnt", stall_cycles_o, 32'd6);
    step();

    // Back-to-back divides, second one killed by an exception.
    drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
    step();
    drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
    step();
    drive(0, 0, 1, 1, 0, 0, 0, 32'h0);
    chk("div2.done.stall", 32'(stall_o), 32'h0);
    step();
    drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
    chk_out("div2.restart", 4'b0111, 0, 32'h0, 1, 0);
    step();
    drive(0, 0, 1, 0, 0, 1, 0, 32'h0);
    chk_out("divexc", 4'b0000, 1, 32'hBFC00380, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk_out("divexc.next", 4'b0000, 0, 32'h0, 0, 0);
    chk("divexc.cnt", stall_cycles_o, 32'd9);
    step();

    // Exception with idle bus; flush beats fetch stall and divide start.
    drive(1, 0, 1, 0, 0, 1, 0, 32'h11111111);
    chk_out("exc", 4'b0000, 1, 32'hBFC00380, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("exc.next.flush", 32'(flush_o), 32'h0);
    step();

    // ERET behind 3 cycles of bus traffic; EPC changes mid-drain.
    drive(0, 0, 0, 0, 1, 1, 1, 32'h80001234);
    chk_out("eret.c0", 4'b1111, 0, 32'h0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 1, 0, 32'hDEADBEEF);
    chk_out("eret.c1", 4'b1111, 0, 32'h0, 0, 0);
    step();
    drive(0, 0, 1, 0, 1, 0, 1, 32'hDEADBEEF);
    chk_out("eret.c2", 4'b1111, 0, 32'h0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    chk_out("eret.c3", 4'b0000, 1, 32'h80001234, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk_out("eret.c4", 4'b0000, 0, 32'h0, 0, 0);
    chk("eret.cnt", stall_cycles_o, 32'd12);
    step();

    // Plain stall patterns in RUN.
    drive(0, 0, 0, 0, 1, 0, 0, 32'h0);
    chk("pat.mem", 32'(stall_o), 32'hF);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("pat.if", 32'(stall_o), 32'h1);
    step();
    drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("pat.lu_if", 32'(stall_o), 32'h3);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("pat.cnt", stall_cycles_o, 32'd15);
    step();

    // Exception in DIV_WAIT with busy bus: cancel now, flush after drain.
    drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
    step();
    drive(0, 0, 1, 0, 1, 1, 0, 32'h0);
    chk_out("divdrain.c1", 4'b1111, 0, 32'h0, 0, 1);
    step();
    drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
    chk_out("divdrain.c2", 4'b0000, 1, 32'hBFC00380, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("divdrain.cnt", stall_cycles_o, 32'd17);
    step();

    // Reset mid-divide.
    drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
    step();
    reset_i = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 32'h0);
    chk_out("rstdiv.in", 4'b0000, 0, 32'h0, 0, 0);
    step();
    reset_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk_out("rstdiv.after", 4'b0000, 0, 32'h0, 0, 0);
    chk("rstdiv.cnt", stall_cycles_o, 32'd0);
    step();

    // Counter saturation from a preload.
    sc_load = 1'b1; sc_value = 32'hFFFFFFFE;
    step();
    sc_load = 1'b0; sc_inc = 1'b1;
    #4;
    chk("sat.load", sc_count, 32'hFFFFFFFE);
    for (int k = 1; k <= 3; k++) begin
      step();
      #4;
      chk($sformatf("sat.inc%0d", k), sc_count, 32'hFFFFFFFF);
    end
    sc_inc = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
